// File: rtl/uart_avm_pkg.sv
// Shared definitions for the UART Avalon-MM arbiter, loader and reporter:
// arbiter FSM states, UART register offsets and STATUS bit positions.
package uart_avm_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int TX_OK_BIT = 6;
  localparam int RX_OK_BIT = 7;

  localparam logic [3:0] HOLD_SAT = 4'hF;

endpackage

// File: rtl/uart_avm_arbiter_rr_pick2.sv
// Two-way round-robin picker: with both requesting, the index that was not
// served last wins; otherwise the lone requester wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o
);

  always_comb begin
    winner_o = (&req_i) ? ~last_i : req_i[1];
  end

endmodule

// File: rtl/uart_avm_arbiter.sv
// Shares the UART Avalon-MM slave between the RX loader (r0) and the TX
// reporter (r1): round-robin grant per transfer with bounded optional lock.
module uart_avm_arbiter
  import uart_avm_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  input  logic              r0_lock,
  output logic              r0_waitrequest,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  input  logic              r1_lock,
  output logic              r1_waitrequest,
  output logic [DATA_W-1:0] rd_readdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              proto_err
);

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [3:0] hold_q, hold_d;
  logic       proto_err_q, proto_err_d;

  logic [1:0]        req;
  logic              winner;
  logic              own_req, oth_req, own_lock, done, active;
  logic              g_read, g_write;
  logic [ADDR_W-1:0] g_address;
  logic [DATA_W-1:0] g_writedata;

  assign req = {r1_read | r1_write, r0_read | r0_write};

  rr_pick2 u_pick (
    .req_i    (req),
    .last_i   (rr_ptr_q),
    .winner_o (winner)
  );

  assign own_req     = grant_q ? req[1] : req[0];
  assign oth_req     = grant_q ? req[0] : req[1];
  assign own_lock    = grant_q ? r1_lock : r0_lock;
  assign g_read      = grant_q ? r1_read : r0_read;
  assign g_write     = grant_q ? r1_write : r0_write;
  assign g_address   = grant_q ? r1_address : r0_address;
  assign g_writedata = grant_q ? r1_writedata : r0_writedata;
  assign done        = own_req && !avm_waitrequest;

  // NOTE: reset gates the slave side combinationally so an in-flight
  // transfer is cut in the very cycle reset is asserted, not one edge later.
  assign active = (state_q == S_GRANT) && !avm_rst;

  assign avm_read       = active & g_read;
  assign avm_write      = active & g_write & ~g_read;
  assign avm_address    = active ? g_address : '0;
  assign avm_writedata  = active ? g_writedata : '0;
  assign r0_waitrequest = (active && !grant_q) ? avm_waitrequest : 1'b1;
  assign r1_waitrequest = (active && grant_q) ? avm_waitrequest : 1'b1;
  assign rd_readdata    = avm_readdata;
  assign proto_err      = proto_err_q;

  // NOTE: every next-state signal takes its hold value first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    proto_err_d = proto_err_q | (r0_read & r0_write) | (r1_read & r1_write);
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = winner;
          hold_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (done) begin
          rr_ptr_d = grant_q;
          hold_d   = (hold_q == HOLD_SAT) ? hold_q : hold_q + 4'd1;
          // The lock is honoured only until the waiting requester has been
          // made to sit through MAX_HOLD locked transfers.
          if (own_lock && (!oth_req || (int'(hold_q) + 1 < MAX_HOLD))) begin
            state_d = S_GRANT;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!own_req && oth_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      hold_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
